// File: rtl/sr_drv_pkg.sv
// Shared types and constants for the SR latch command driver.
package sr_drv_pkg;

  // Command sequencer phases.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Which latch input a command drives.
  typedef enum logic {
    CMD_SET   = 1'b0,
    CMD_RESET = 1'b1
  } cmd_t;

  localparam logic [7:0] DROP_MAX = 8'd255;

  // Saturating add for the drop counter; never wraps past DROP_MAX.
  function automatic logic [7:0] sat_add(input logic [7:0] base, input logic [1:0] inc);
    logic [8:0] sum;
    sum = {1'b0, base} + {7'd0, inc};
    if (sum > {1'b0, DROP_MAX}) begin
      return DROP_MAX;
    end
    return sum[7:0];
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, debounce counter and registered rising-edge pulse
// for one raw push-button input.
module btn_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic req
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync_meta;
  logic          sync_level;
  logic          db_level;
  logic          db_prev;
  logic          req_reg;
  logic [CW-1:0] cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta  <= 1'b0;
      sync_level <= 1'b0;
    end else begin
      sync_meta  <= btn;
      sync_level <= sync_meta;
    end
  end

  // Accept a new level only after it differs for DB_CYCLES consecutive cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_level <= 1'b0;
      cnt      <= '0;
    end else if (sync_level == db_level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      db_level <= ~db_level;
      cnt      <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // One-cycle pulse on each debounced rising edge; falling edges are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_prev <= 1'b0;
      req_reg <= 1'b0;
    end else begin
      db_prev <= db_level;
      req_reg <= db_level & ~db_prev;
    end
  end

  assign req = req_reg;

endmodule

// File: rtl/sr_latch_driver.sv
// Turns debounced set/reset button presses into framed S/R + C strobe
// commands for a clocked SR latch, with arbitration and drop counting.
module sr_latch_driver #(
  parameter int DB_CYCLES     = 4,
  parameter int STROBE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_set,
  input  logic       btn_reset,
  output logic       latch_s,
  output logic       latch_r,
  output logic       latch_c,
  output logic       busy,
  output logic       q_expect,
  output logic [7:0] drop_cnt
);

  import sr_drv_pkg::*;

  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);

  logic       req_set;
  logic       req_reset;

  state_t     state_reg, state_next;
  cmd_t       cmd_reg, cmd_next;
  logic [3:0] scnt_reg, scnt_next;
  logic       q_reg, q_next;
  logic [7:0] drop_reg, drop_next;
  logic [1:0] drop_inc;

  logic       s_reg, s_next;
  logic       r_reg, r_next;
  logic       c_reg, c_next;
  logic       busy_reg, busy_next;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_set (
    .clk (clk),
    .rst (rst),
    .btn (btn_set),
    .req (req_set)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_reset (
    .clk (clk),
    .rst (rst),
    .btn (btn_reset),
    .req (req_reset)
  );

  // Sequencer state, drop counter and registered latch drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cmd_reg   <= CMD_SET;
      scnt_reg  <= '0;
      q_reg     <= 1'b0;
      drop_reg  <= '0;
      s_reg     <= 1'b0;
      r_reg     <= 1'b0;
      c_reg     <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cmd_reg   <= cmd_next;
      scnt_reg  <= scnt_next;
      q_reg     <= q_next;
      drop_reg  <= drop_next;
      s_reg     <= s_next;
      r_reg     <= r_next;
      c_reg     <= c_next;
      busy_reg  <= busy_next;
    end
  end

  // Next state, arbitration, and outputs decoded from the next state so that
  // the registered latch pins line up with the state they belong to.
  always_comb begin
    state_next = state_reg;
    cmd_next   = cmd_reg;
    scnt_next  = scnt_reg;
    q_next     = q_reg;
    drop_inc   = 2'd0;

    case (state_reg)
      IDLE: begin
        scnt_next = '0;
        if (req_reset) begin
          state_next = SETUP;
          cmd_next   = CMD_RESET;
          if (req_set) begin
            drop_inc = 2'd1;   // reset wins a tie; the set is lost
          end
        end else if (req_set) begin
          state_next = SETUP;
          cmd_next   = CMD_SET;
        end
      end
      SETUP: begin
        state_next = STROBE;
        scnt_next  = '0;
      end
      STROBE: begin
        if (scnt_reg == STROBE_LAST) begin
          state_next = HOLD;
          q_next     = (cmd_reg == CMD_SET);
        end else begin
          scnt_next = scnt_reg + 4'd1;
        end
      end
      HOLD: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Any request seen while a command is in flight is discarded.
    if (state_reg != IDLE) begin
      drop_inc = {1'b0, req_set} + {1'b0, req_reset};
    end

    drop_next = sat_add(drop_reg, drop_inc);
    busy_next = (state_next != IDLE);
    s_next    = busy_next && (cmd_next == CMD_SET);
    r_next    = busy_next && (cmd_next == CMD_RESET);
    c_next    = (state_next == STROBE);
  end

  assign latch_s  = s_reg;
  assign latch_r  = r_reg;
  assign latch_c  = c_reg;
  assign busy     = busy_reg;
  assign q_expect = q_reg;
  assign drop_cnt = drop_reg;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: two instances (STROBE_CYCLES 2 and 8) share the
// same buttons; a cycle-level behavioural model is checked every cycle and
// directed scenarios check hand-computed values.
module tb_sr_latch_driver;

  localparam int DB = 4;
  localparam int SC_A = 2;
  localparam int SC_B = 8;
  localparam logic [255:0] DB_MASK = (256'd1 << DB) - 256'd1;

  logic       clk;
  logic       rst;
  logic       btn_set;
  logic       btn_reset;
  logic [1:0] o_s, o_r, o_c, o_busy, o_q;
  logic [7:0] o_drop [2];

  int total = 0;
  int bad   = 0;

  sr_latch_driver #(.DB_CYCLES(DB), .STROBE_CYCLES(SC_A)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .btn_set   (btn_set),
    .btn_reset (btn_reset),
    .latch_s   (o_s[0]),
    .latch_r   (o_r[0]),
    .latch_c   (o_c[0]),
    .busy      (o_busy[0]),
    .q_expect  (o_q[0]),
    .drop_cnt  (o_drop[0])
  );

  sr_latch_driver #(.DB_CYCLES(DB), .STROBE_CYCLES(SC_B)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .btn_set   (btn_set),
    .btn_reset (btn_reset),
    .latch_s   (o_s[1]),
    .latch_r   (o_r[1]),
    .latch_c   (o_c[1]),
    .busy      (o_busy[1]),
    .q_expect  (o_q[1]),
    .drop_cnt  (o_drop[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // ---------------- behavioural model ----------------
  // Button path (index 0 = set, 1 = reset): two-cycle delay, then the
  // debounced level flips once the last DB synchronized samples all disagree
  // with it; a request pulse follows each debounced rise by one cycle.
  bit           m_s1  [2] = '{0, 0};
  bit           m_y   [2] = '{0, 0};
  bit           m_db  [2] = '{0, 0};
  bit           m_dbp [2] = '{0, 0};
  bit           m_req [2] = '{0, 0};
  logic [255:0] m_hist[2] = '{256'd0, 256'd0};
  // Command timeline per instance: pos = cycles since command start
  // (0 = first busy cycle), -1 when idle. A command lasts SC+2 cycles,
  // C is high for positions 1..SC, Q is updated when position SC+1 begins.
  int           pos   [2] = '{-1, -1};
  bit           m_set [2] = '{0, 0};
  bit           m_q   [2] = '{0, 0};
  int           m_drop[2] = '{0, 0};

  function automatic int sc_of(input int j);
    return (j == 0) ? SC_A : SC_B;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 0; m_y[b] = 0; m_db[b] = 0; m_dbp[b] = 0; m_req[b] = 0;
        m_hist[b] = '0;
      end
      for (int j = 0; j < 2; j++) begin
        pos[j] = -1; m_set[j] = 0; m_q[j] = 0; m_drop[j] = 0;
      end
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (pos[j] < 0) begin
          if (m_req[1]) begin
            pos[j] = 0;
            m_set[j] = 0;
            if (m_req[0]) m_drop[j] = sat255(m_drop[j] + 1);
          end else if (m_req[0]) begin
            pos[j] = 0;
            m_set[j] = 1;
          end
        end else begin
          m_drop[j] = sat255(m_drop[j] + int'(m_req[0]) + int'(m_req[1]));
          pos[j]++;
          if (pos[j] == sc_of(j) + 1) m_q[j] = m_set[j];
          if (pos[j] > sc_of(j) + 1) pos[j] = -1;
        end
      end
      for (int b = 0; b < 2; b++) begin
        m_req[b]  = m_db[b] & ~m_dbp[b];
        m_dbp[b]  = m_db[b];
        m_hist[b] = {m_hist[b][254:0], m_y[b]};
        if ((m_hist[b] & DB_MASK) == (m_db[b] ? 256'd0 : DB_MASK)) m_db[b] = ~m_db[b];
        m_y[b]    = m_s1[b];
        m_s1[b]   = (b == 0) ? btn_set : btn_reset;
      end
    end
  end

  // Every-cycle comparison against the model, plus the S/R exclusion check.
  always @(negedge clk) begin
    for (int j = 0; j < 2; j++) begin
      string nm;
      int    eb;
      nm = (j == 0) ? "a" : "b";
      eb = (pos[j] >= 0) ? 1 : 0;
      cmp({nm, ".busy"},     int'(o_busy[j]), eb);
      cmp({nm, ".latch_c"},  int'(o_c[j]), (pos[j] >= 1 && pos[j] <= sc_of(j)) ? 1 : 0);
      cmp({nm, ".latch_s"},  int'(o_s[j]), (eb == 1 && m_set[j]) ? 1 : 0);
      cmp({nm, ".latch_r"},  int'(o_r[j]), (eb == 1 && !m_set[j]) ? 1 : 0);
      cmp({nm, ".q_expect"}, int'(o_q[j]), int'(m_q[j]));
      cmp({nm, ".drop_cnt"}, int'(o_drop[j]), m_drop[j]);
      total++;
      assert (!(o_s[j] && o_r[j])) else begin
        bad++;
        $error("FAIL sr_overlap %s: latch_s=%0d latch_r=%0d, want not both 1", nm, o_s[j], o_r[j]);
      end
    end
  end

  // ---------------- directed scenario helpers ----------------
  int          a_first_s;
  int          a_s_n, a_r_n, a_busy_n, b_s_n, b_r_n, b_busy_n;
  logic [15:0] a_c_pat, a_q_pat;

  task automatic clear_stats();
    a_first_s = -1;
    a_s_n = 0; a_r_n = 0; a_busy_n = 0;
    b_s_n = 0; b_r_n = 0; b_busy_n = 0;
    a_c_pat = '0; a_q_pat = '0;
  endtask

  task automatic observe(input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (o_s[0] && a_first_s < 0) a_first_s = k;
      a_s_n    += int'(o_s[0]);
      a_r_n    += int'(o_r[0]);
      a_busy_n += int'(o_busy[0]);
      b_s_n    += int'(o_s[1]);
      b_r_n    += int'(o_r[1]);
      b_busy_n += int'(o_busy[1]);
      if (o_busy[0]) begin
        a_c_pat = {a_c_pat[14:0], o_c[0]};
        a_q_pat = {a_q_pat[14:0], o_q[0]};
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; btn_set = 1'b1; btn_reset = 1'b0;

    // Reset held 3 cycles with btn_set high: everything stays 0.
    tick(3);
    cmp("rst.latch_s", int'(o_s[0]), 0);
    cmp("rst.latch_r", int'(o_r[0]), 0);
    cmp("rst.latch_c", int'(o_c[0]), 0);
    cmp("rst.busy", int'(o_busy[0]), 0);
    cmp("rst.q_expect", int'(o_q[0]), 0);
    cmp("rst.drop_cnt", int'(o_drop[0]), 0);
    $display("test reset: outputs a s=%0d r=%0d c=%0d busy=%0d q=%0d drop=%0d",
             o_s[0], o_r[0], o_c[0], o_busy[0], o_q[0], o_drop[0]);

    // Release: first sampled btn_set at the next edge, latch_s 7 cycles later.
    rst = 1'b0;
    clear_stats();
    observe(20);
    cmp("lat.latency", a_first_s - 1, 7);
    cmp("lat.a_busy_cycles", a_busy_n, 4);
    cmp("lat.b_busy_cycles", b_busy_n, SC_B + 2);
    cmp("lat.a_c_pattern", int'(a_c_pat[3:0]), 4'b0110);
    cmp("lat.q_after", int'(o_q[0]), 1);
    $display("test first_set: latency=%0d busy=%0d c_pat=%b", a_first_s - 1, a_busy_n, a_c_pat[3:0]);
    btn_set = 1'b0;
    tick(25);

    // Glitch rejection: 3-cycle reset pulses never get through.
    clear_stats();
    for (int i = 0; i < 10; i++) begin
      btn_reset = 1'b1; observe(3);
      btn_reset = 1'b0; observe(3);
    end
    observe(12);
    cmp("glitch.a_busy", a_busy_n, 0);
    cmp("glitch.b_busy", b_busy_n, 0);
    cmp("glitch.drop_cnt", int'(o_drop[0]), 0);
    cmp("glitch.q_expect", int'(o_q[0]), 1);
    $display("test glitch: busy_a=%0d busy_b=%0d drop=%0d q=%0d", a_busy_n, b_busy_n, o_drop[0], o_q[0]);

    // Simultaneous press: reset wins, one drop.
    clear_stats();
    btn_set = 1'b1; btn_reset = 1'b1;
    observe(20);
    cmp("simul.a_r_cycles", a_r_n, 4);
    cmp("simul.a_s_cycles", a_s_n, 0);
    cmp("simul.b_r_cycles", b_r_n, SC_B + 2);
    cmp("simul.a_drop", int'(o_drop[0]), 1);
    cmp("simul.b_drop", int'(o_drop[1]), 1);
    cmp("simul.q_expect", int'(o_q[0]), 0);
    $display("test simultaneous: r=%0d s=%0d drop=%0d q=%0d", a_r_n, a_s_n, o_drop[0], o_q[0]);
    btn_set = 1'b0; btn_reset = 1'b0;
    tick(25);

    // Set command held 20 cycles: S for 4 cycles, C in the middle two, Q at HOLD.
    clear_stats();
    btn_set = 1'b1;
    observe(20);
    btn_set = 1'b0;
    cmp("set.s_cycles", a_s_n, 4);
    cmp("set.r_cycles", a_r_n, 0);
    cmp("set.c_pattern", int'(a_c_pat[3:0]), 4'b0110);
    cmp("set.q_pattern", int'(a_q_pat[3:0]), 4'b0001);
    $display("test set: s=%0d c_pat=%b q_pat=%b", a_s_n, a_c_pat[3:0], a_q_pat[3:0]);
    tick(25);

    // Busy drop: reset request lands while instance b is in STROBE.
    clear_stats();
    btn_set = 1'b1;
    observe(5);
    btn_reset = 1'b1;
    observe(25);
    cmp("busy.b_drop", int'(o_drop[1]), 2);
    cmp("busy.b_r_cycles", b_r_n, 0);
    cmp("busy.b_s_cycles", b_s_n, SC_B + 2);
    $display("test busy_drop: b_drop=%0d b_r=%0d b_s=%0d", o_drop[1], b_r_n, b_s_n);
    btn_set = 1'b0; btn_reset = 1'b0;
    tick(25);

    // Saturation: 300 simultaneous presses, each dropping one set request.
    for (int i = 0; i < 300; i++) begin
      btn_set = 1'b1; btn_reset = 1'b1; tick(6);
      btn_set = 1'b0; btn_reset = 1'b0; tick(6);
    end
    tick(25);
    cmp("sat.a_drop", int'(o_drop[0]), 255);
    cmp("sat.b_drop", int'(o_drop[1]), 255);
    $display("test saturation: a_drop=%0d b_drop=%0d", o_drop[0], o_drop[1]);

    // Abort: reset while b is strobing and a has already latched Q=1.
    btn_set = 1'b1;
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (o_q[0] && o_c[1]) seen = 1;
    end
    cmp("abort.reached_strobe", int'(seen), 1);
    rst = 1'b1;
    tick(1);
    cmp("abort.b_latch_c", int'(o_c[1]), 0);
    cmp("abort.b_latch_s", int'(o_s[1]), 0);
    cmp("abort.b_busy", int'(o_busy[1]), 0);
    cmp("abort.a_q_expect", int'(o_q[0]), 0);
    cmp("abort.a_drop", int'(o_drop[0]), 0);
    $display("test abort: b_c=%0d b_s=%0d b_busy=%0d a_q=%0d", o_c[1], o_s[1], o_busy[1], o_q[0]);
    rst = 1'b0; btn_set = 1'b0;
    tick(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
- Upstream stage for the clocked SR latch circuit (inputs C, S, R; outputs Q, Qbar).
- Turns two raw push-button inputs (set, reset) into clean, well-formed latch commands.
- Each command is a glitch-free S or R level framed around a single C strobe, with setup and hold margins.
- Guarantees the latch never sees S and R high together, and tracks the expected Q for on-board checking.

Parameters:
- DB_CYCLES, 4, consecutive stable cycles required before a synchronized input level is accepted; legal range 1..255.
- STROBE_CYCLES, 2, width of the C pulse in clock cycles; legal range 1..15.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- btn_set  in  1  raw asynchronous set button.
- btn_reset  in  1  raw asynchronous reset button.
- latch_s  out  1  drives latch S.
- latch_r  out  1  drives latch R.
- latch_c  out  1  drives latch C (strobe).
- busy  out  1  high while a command is in flight (state != IDLE).
- q_expect  out  1  Q value the latch must hold after the last completed command.
- drop_cnt  out  8  count of requests dropped; saturates at 255.

Behaviour:
- Reset:
  - rst sampled high at a clock edge forces all outputs to 0 (latch_s, latch_r, latch_c, busy, q_expect, drop_cnt).
  - It also clears both synchronizer stages, debounced levels, debounce counters and edge registers, and sets FSM = IDLE.
  - Reset mid-command aborts the command; outputs are low after that same edge, and q_expect returns to 0.
- Synchronizer:
  - Each button passes through two flops, giving sync level y.
- Debounce (per input):
  - Counter width is clog2(DB_CYCLES+1).
  - If y == db_level, the counter clears.
  - Otherwise the counter increments. When it would reach DB_CYCLES, db_level toggles and the counter clears.
  - Pulses on y shorter than DB_CYCLES cycles never change db_level.
- Edge detect:
  - The req flop is registered: req = db_level & ~db_level_prev, a one-cycle pulse per debounced rising edge.
  - A debounced falling edge generates nothing.
- FSM states: IDLE, SETUP, STROBE, HOLD.
  - IDLE: all latch outputs 0. If req_reset=1 go to SETUP with cmd=RESET. Else if req_set=1 go to SETUP with cmd=SET.
  - SETUP (1 cycle): latch_s = (cmd==SET), latch_r = (cmd==RESET), latch_c = 0. Go to STROBE.
  - STROBE (STROBE_CYCLES cycles, counted by a 4-bit counter): S/R held, latch_c = 1. Then go to HOLD; q_expect <= (cmd==SET) on that transition.
  - HOLD (1 cycle): S/R held, latch_c = 0. Go to IDLE.
- Timing:
  - A command occupies STROBE_CYCLES+2 cycles; busy=1 exactly in SETUP/STROBE/HOLD.
  - All latch outputs are registered; no combinational path from buttons to outputs.
- Arbitration:
  - req_reset and req_set high in the same IDLE cycle: reset wins, set is dropped, drop_cnt += 1.
  - Any req arriving while FSM != IDLE is dropped and counted; two drops in one cycle add 2.
  - drop_cnt saturates at 255 and never wraps.
- Invariants:
  - latch_s & latch_r == 0 always.
  - latch_c == 1 only in STROBE.
  - S/R are stable for the full interval from one cycle before C rises until one cycle after C falls.
- Latency: a button level change present before clock edge N makes latch_s/latch_r rise after edge N+DB_CYCLES+3 (defaults: 7 cycles).

Decomposition:
- Package sr_drv_pkg holds:
  - state enum {IDLE, SETUP, STROBE, HOLD};
  - cmd enum {CMD_SET, CMD_RESET};
  - DROP_MAX = 8'd255.
- One sub-module, btn_debounce (2-flop synchronizer + debounce counter + registered rising-edge pulse), parameterised by DB_CYCLES and instantiated twice.
- FSM, arbitration and drop counter live in the top.

Test Plan:
- Reset: hold rst 3 cycles with btn_set=1 -> all outputs 0. After release, with defaults, latch_s rises 7 cycles after the first sampled btn_set, and busy is high for 4 cycles.
- Set command, defaults: btn_set high 20 cycles -> latch_s high 4 cycles, latch_c high exactly cycles 2-3 of those 4, q_expect=1 from the HOLD cycle, latch_r stays 0.
- Glitch rejection: btn_reset pulses of 3 cycles, repeated 10 times with 3-cycle gaps -> no latch activity, drop_cnt=0, q_expect unchanged.
- Simultaneous: btn_set and btn_reset rise on the same cycle -> one RESET command (latch_r pulse), drop_cnt=1, q_expect=0.
- Busy drop: with STROBE_CYCLES=8, set command, then a reset request whose edge pulse lands during STROBE -> reset ignored, drop_cnt=1, latch_r stays 0.
- Saturation and abort:
  - Force 300 dropped requests -> drop_cnt=255.
  - Assert rst during STROBE -> latch_c, latch_s and busy are 0 on the next cycle, and q_expect=0.
- Checker (all runs): assert !(latch_s && latch_r) every cycle.
